// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter
//   Two-requester, whole-packet round-robin arbiter for the shared UDP TX path.
//   A grant covers one header handshake followed by payload beats through tlast.
//   A payload stall watchdog turns a stuck packet into a single tlast/tuser error
//   beat toward the stack, then silently drains the rest of the source packet.
//   The header and AXI-stream interfaces are flattened into plain ports. The
//   header is carried as one packed HDR_WIDTH-bit field bundle.
//   TIMEOUT_CYCLES must be below 2**CNT_WIDTH. A value of 0 disables the watchdog.
//   Optional build macro: UDP_TX_ARB_STATS_EN adds pkt_count0, pkt_count1 and
//   abort_count outputs.
module udp_tx_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int HDR_WIDTH      = 80,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // requester 0
    input  logic                  s0_hdr_valid_i,
    output logic                  s0_hdr_ready_o,
    input  logic [HDR_WIDTH-1:0]  s0_hdr_data_i,
    input  logic [DATA_WIDTH-1:0] s0_tdata_i,
    input  logic                  s0_tvalid_i,
    output logic                  s0_tready_o,
    input  logic                  s0_tlast_i,
    input  logic                  s0_tuser_i,
    // requester 1
    input  logic                  s1_hdr_valid_i,
    output logic                  s1_hdr_ready_o,
    input  logic [HDR_WIDTH-1:0]  s1_hdr_data_i,
    input  logic [DATA_WIDTH-1:0] s1_tdata_i,
    input  logic                  s1_tvalid_i,
    output logic                  s1_tready_o,
    input  logic                  s1_tlast_i,
    input  logic                  s1_tuser_i,
    // toward the UDP stack
    output logic                  m_hdr_valid_o,
    input  logic                  m_hdr_ready_i,
    output logic [HDR_WIDTH-1:0]  m_hdr_data_o,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tlast_o,
    output logic                  m_tuser_o,
    // status
    output logic [1:0]            grant,
    output logic                  busy
`ifdef UDP_TX_ARB_STATS_EN
    ,
    output logic [31:0]           pkt_count0,
    output logic [31:0]           pkt_count1,
    output logic [CNT_WIDTH-1:0]  abort_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_ABORT,
        S_DRAIN
    } state_e;

    localparam bit                 WD_EN     = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_WIDTH:0] STALL_LIM = (CNT_WIDTH+1)'(TIMEOUT_CYCLES);

    // Requester signals packed per port so the owner can be selected by index.
    logic [1:0]                 hvalid, hready, tvalid, tready, tlast, tuser;
    logic [1:0][HDR_WIDTH-1:0]  hdata;
    logic [1:0][DATA_WIDTH-1:0] tdata;

    assign hvalid = {s1_hdr_valid_i, s0_hdr_valid_i};
    assign hdata  = {s1_hdr_data_i,  s0_hdr_data_i};
    assign tvalid = {s1_tvalid_i,    s0_tvalid_i};
    assign tdata  = {s1_tdata_i,     s0_tdata_i};
    assign tlast  = {s1_tlast_i,     s0_tlast_i};
    assign tuser  = {s1_tuser_i,     s0_tuser_i};

    assign s0_hdr_ready_o = hready[0];
    assign s1_hdr_ready_o = hready[1];
    assign s0_tready_o    = tready[0];
    assign s1_tready_o    = tready[1];

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 last_q, last_d;     // index of the port that finished most recently
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [CNT_WIDTH:0]   stall_inc;          // one bit wider so the limit test cannot wrap
    logic                 sel;

    // grant is one-hot whenever it is meaningful, so bit 1 is the owner index
    assign sel       = grant_q[1];
    assign stall_inc = {1'b0, stall_q} + (CNT_WIDTH+1)'(1);

    assign grant = grant_q;
    assign busy  = (state_q != S_IDLE);

    // State, owner, round-robin pointer and stall counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            stall_q <= stall_d;
        end
    end

    // Next-state logic and the combinational mux between owner and stack
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        stall_d       = stall_q;
        hready        = 2'b00;
        tready        = 2'b00;
        m_hdr_valid_o = 1'b0;
        m_hdr_data_o  = hdata[sel];
        m_tvalid_o    = 1'b0;
        m_tdata_o     = tdata[sel];
        m_tlast_o     = tlast[sel];
        m_tuser_o     = tuser[sel];

        case (state_q)
            S_IDLE: begin
                stall_d = '0;
                if (hvalid != 2'b00) begin
                    state_d = S_HDR;
                    // on a tie the port that did not finish last wins
                    if (hvalid == 2'b11) grant_d = last_q ? 2'b01 : 2'b10;
                    else                 grant_d = hvalid;
                end
            end

            S_HDR: begin
                m_hdr_valid_o = hvalid[sel];
                hready[sel]   = m_hdr_ready_i;
                if (hvalid[sel] && m_hdr_ready_i) state_d = S_PAYLOAD;
            end

            S_PAYLOAD: begin
                m_tvalid_o  = tvalid[sel];
                tready[sel] = m_tready_i;
                if (tvalid[sel] && m_tready_i) begin
                    // any transfer is progress, even if the stall limit was due now
                    stall_d = '0;
                    if (tlast[sel]) begin
                        last_d  = sel;
                        grant_d = 2'b00;
                        state_d = S_IDLE;
                    end
                end else if (!tvalid[sel]) begin
                    // only an empty source counts as a stall; stack backpressure does not
                    stall_d = (&stall_q) ? stall_q : stall_inc[CNT_WIDTH-1:0];
                    if (WD_EN && (stall_inc >= STALL_LIM)) state_d = S_ABORT;
                end
            end

            S_ABORT: begin
                // terminate the packet toward the stack with an error-marked beat
                m_tvalid_o = 1'b1;
                m_tlast_o  = 1'b1;
                m_tuser_o  = 1'b1;
                m_tdata_o  = '0;
                if (m_tready_i) state_d = S_DRAIN;
            end

            S_DRAIN: begin
                // swallow the rest of the source packet; nothing reaches the stack
                tready[sel] = 1'b1;
                if (tvalid[sel] && tlast[sel]) begin
                    last_d  = sel;
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end
            end

            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef UDP_TX_ARB_STATS_EN
    logic                 pkt_fire, abort_fire;
    logic [31:0]          pkt0_q, pkt1_q;
    logic [CNT_WIDTH-1:0] abort_q;

    // only tlast beats forwarded in PAYLOAD count; drained packets are excluded
    assign pkt_fire   = (state_q == S_PAYLOAD) && tvalid[sel] && m_tready_i && tlast[sel];
    assign abort_fire = (state_q == S_ABORT) && m_tready_i;

    assign pkt_count0  = pkt0_q;
    assign pkt_count1  = pkt1_q;
    assign abort_count = abort_q;

    // Completed-packet and abort counters, free-running and wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt0_q  <= '0;
            pkt1_q  <= '0;
            abort_q <= '0;
        end else begin
            if (pkt_fire && !sel) pkt0_q <= pkt0_q + 32'd1;
            if (pkt_fire &&  sel) pkt1_q <= pkt1_q + 32'd1;
            if (abort_fire)       abort_q <= abort_q + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
